// File: rtl/mdio_link_poll.sv
// Polls Basic Status of PHYs 0-3 with Clause-22 MDIO reads and publishes each link bit.
// One read = 128*CLK_DIV busy cycles plus a one-cycle o_stat_vld pulse; no backpressure.
module mdio_link_poll #(
  parameter int          CLK_DIV       = 16,
  parameter logic [31:0] POLL_INTERVAL = 32'd1000000,
  parameter logic [4:0]  STAT_REG      = 5'd1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_initDn,
  output logic        o_mdc,
  inout  wire         b_mdio,
  output logic [3:0]  o_link_up,
  output logic        o_stat_vld,
  output logic [1:0]  o_phy_idx,
  output logic [15:0] o_stat_data,
  output logic        o_stat_err,
  output logic        o_busy
);

  localparam int PH_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_UPDATE, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [PH_W-1:0] phase, phase_nxt;
  logic [5:0]  bit_cnt, bit_nxt;
  logic [1:0]  idx, idx_nxt;
  logic        mdo, mdo_nxt;
  logic        oe, oe_nxt;
  logic [15:0] shreg, shreg_nxt;
  logic        ta_err, ta_err_nxt;
  logic [31:0] wait_cnt, wait_nxt;
  logic        mdc_nxt, busy_nxt, vld_nxt, err_nxt;
  logic [3:0]  link_nxt;
  logic [1:0]  phy_idx_nxt;
  logic [15:0] data_nxt;
  logic [5:0]  bit_inc;

  assign b_mdio  = oe ? mdo : 1'bz;
  assign bit_inc = bit_cnt + 6'd1;

  // Driven header: preamble, ST=01, OP=10, PHYAD, REGAD; bits 46+ are turnaround/data.
  function automatic logic frame_bit(input logic [5:0] b, input logic [1:0] phy);
    logic [45:0] hdr;
    hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 3'b000, phy, STAT_REG};
    return (b <= 6'd45) ? hdr[6'd45 - b] : 1'b0;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      phase       <= '0;
      bit_cnt     <= '0;
      idx         <= '0;
      mdo         <= 1'b0;
      oe          <= 1'b0;
      shreg       <= '0;
      ta_err      <= 1'b0;
      wait_cnt    <= '0;
      o_mdc       <= 1'b0;
      o_busy      <= 1'b0;
      o_stat_vld  <= 1'b0;
      o_phy_idx   <= '0;
      o_stat_data <= '0;
      o_stat_err  <= 1'b0;
      o_link_up   <= '0;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      bit_cnt     <= bit_nxt;
      idx         <= idx_nxt;
      mdo         <= mdo_nxt;
      oe          <= oe_nxt;
      shreg       <= shreg_nxt;
      ta_err      <= ta_err_nxt;
      wait_cnt    <= wait_nxt;
      o_mdc       <= mdc_nxt;
      o_busy      <= busy_nxt;
      o_stat_vld  <= vld_nxt;
      o_phy_idx   <= phy_idx_nxt;
      o_stat_data <= data_nxt;
      o_stat_err  <= err_nxt;
      o_link_up   <= link_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    phase_nxt   = phase;
    bit_nxt     = bit_cnt;
    idx_nxt     = idx;
    mdo_nxt     = mdo;
    oe_nxt      = oe;
    shreg_nxt   = shreg;
    ta_err_nxt  = ta_err;
    wait_nxt    = wait_cnt;
    mdc_nxt     = o_mdc;
    busy_nxt    = o_busy;
    vld_nxt     = 1'b0;
    phy_idx_nxt = o_phy_idx;
    data_nxt    = o_stat_data;
    err_nxt     = o_stat_err;
    link_nxt    = o_link_up;

    if (!i_initDn) begin
      state_nxt = S_IDLE;
      phase_nxt = '0;
      bit_nxt   = '0;
      idx_nxt   = '0;
      oe_nxt    = 1'b0;
      wait_nxt  = '0;
      mdc_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      link_nxt  = '0;
    end else begin
      case (state)
        S_FRAME: begin
          if (phase == PH_LAST) begin
            phase_nxt = '0;
            if (!o_mdc) begin
              // Rising MDC: sample what the PHY drove during the low phase.
              mdc_nxt = 1'b1;
              if (bit_cnt == 6'd47) ta_err_nxt = b_mdio;
              if (bit_cnt >= 6'd48) shreg_nxt = {shreg[14:0], b_mdio};
            end else if (bit_cnt == 6'd63) begin
              state_nxt        = S_UPDATE;
              mdc_nxt          = 1'b0;
              busy_nxt         = 1'b0;
              vld_nxt          = 1'b1;
              phy_idx_nxt      = idx;
              data_nxt         = shreg;
              err_nxt          = ta_err;
              link_nxt[idx]    = ~ta_err & shreg[2];
            end else begin
              // Falling MDC: launch next bit so the PHY sees a full half-period of setup.
              bit_nxt = bit_inc;
              mdc_nxt = 1'b0;
              mdo_nxt = frame_bit(bit_inc, idx);
              oe_nxt  = (bit_inc <= 6'd45);
            end
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
        S_UPDATE: begin
          if (idx == 2'd3) begin
            state_nxt = S_WAIT;
            idx_nxt   = '0;
            wait_nxt  = '0;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = S_FRAME;
          end
        end
        S_WAIT: begin
          if (wait_cnt + 32'd1 >= POLL_INTERVAL) state_nxt = S_FRAME;
          else wait_nxt = wait_cnt + 32'd1;
        end
        default: state_nxt = S_FRAME;
      endcase

      if (state != S_FRAME && state_nxt == S_FRAME) begin
        phase_nxt = '0;
        bit_nxt   = '0;
        mdc_nxt   = 1'b0;
        mdo_nxt   = 1'b1;
        oe_nxt    = 1'b1;
        busy_nxt  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mdio_link_poll.sv
// Bench for mdio_link_poll: PHY responder models on the bus plus a cycle-position model of the poll schedule.
module tb_mdio_link_poll;

  localparam int CD   = 3;
  localparam int P    = 100;
  localparam int FR   = 128 * CD;
  localparam int SLOT = FR + 1;
  localparam int R    = 4 * SLOT + P;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_initDn = 1'b0;
  logic        o_mdc;
  wire         b_mdio;
  logic [3:0]  o_link_up;
  logic        o_stat_vld;
  logic [1:0]  o_phy_idx;
  logic [15:0] o_stat_data;
  logic        o_stat_err;
  logic        o_busy;

  mdio_link_poll #(.CLK_DIV(CD), .POLL_INTERVAL(32'(P)), .STAT_REG(5'd1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_initDn(i_initDn), .o_mdc(o_mdc), .b_mdio(b_mdio),
    .o_link_up(o_link_up), .o_stat_vld(o_stat_vld), .o_phy_idx(o_phy_idx),
    .o_stat_data(o_stat_data), .o_stat_err(o_stat_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // PHY responders sharing the pulled-up bus
  logic        phy_oe = 1'b0;
  logic        phy_bit = 1'b1;
  pullup (b_mdio);
  assign b_mdio = phy_oe ? phy_bit : 1'bz;

  logic [15:0] phy_data [4];
  logic [3:0]  present;
  logic [45:0] cap = '0;
  logic [4:0]  paddr = '0;
  logic        resp = 1'b0;
  logic        prev_mdc = 1'b0;
  int          rb = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(posedge i_clk);
    #1;
    if (!o_busy) begin
      rb = 0; phy_oe = 1'b0; resp = 1'b0;
    end else if (o_mdc && !prev_mdc) begin
      if (rb < 46) cap[45-rb] = b_mdio;
      rb++;
    end else if (!o_mdc && prev_mdc) begin
      if (rb == 47) begin
        paddr = cap[9:5];
        resp  = (paddr < 5'd4) && (cap[4:0] == 5'd1) && present[paddr[1:0]];
        if (resp) begin phy_oe = 1'b1; phy_bit = 1'b0; end
      end else if (rb >= 48 && resp) begin
        phy_bit = phy_data[paddr[1:0]][63-rb];
      end
    end
    prev_mdc = o_mdc;
  end

  // Schedule model: position within a round gives busy/mdc/vld directly.
  int   t = 0;
  logic run = 1'b0;
  logic dn, rst_s;
  logic [3:0] link_m = '0;
  int   r, slot, off;
  logic e_busy, e_mdc, e_vld, e_err;
  logic [15:0] e_data;
  logic busy_prev = 1'b0;
  int vld_t[$];
  int vld_i[$];
  int vld_e[$];
  int vld_d[$];
  int start_t[$];

  always begin
    @(posedge i_clk);
    dn = i_initDn;
    rst_s = i_rst;
    #2;
    if (rst_s || i_rst) begin
      run = 1'b0; link_m = '0;
    end else begin
      e_busy = 1'b0; e_mdc = 1'b0; e_vld = 1'b0;
      if (!dn) begin
        run = 1'b0; link_m = '0;
      end else begin
        if (!run) t = 0; else t++;
        run  = 1'b1;
        r    = t % R;
        slot = r / SLOT;
        off  = r % SLOT;
        if (slot < 4) begin
          e_busy = off < FR;
          e_vld  = off == FR;
          e_mdc  = e_busy && ((off / CD) % 2 == 1);
        end
        if (e_vld) begin
          e_err  = ~present[slot];
          e_data = present[slot] ? phy_data[slot] : 16'hFFFF;
          link_m[slot] = ~e_err & e_data[2];
          chk("phy_idx", 64'(o_phy_idx), 64'(slot));
          chk("stat_data", 64'(o_stat_data), 64'(e_data));
          chk("stat_err", 64'(o_stat_err), 64'(e_err));
          chk("frame_hdr", 64'(cap), 64'({32'hFFFF_FFFF, 2'b01, 2'b10, 3'b000, 2'(slot), 5'd1}));
        end
      end
      chk("busy", 64'(o_busy), 64'(e_busy));
      chk("mdc", 64'(o_mdc), 64'(e_mdc));
      chk("stat_vld", 64'(o_stat_vld), 64'(e_vld));
      chk("link_up", 64'(o_link_up), 64'(link_m));
      if (!e_busy) chk("mdio_released", 64'(b_mdio), 64'd1);
      if (o_stat_vld) begin
        vld_t.push_back(t); vld_i.push_back(int'(o_phy_idx));
        vld_e.push_back(int'(o_stat_err)); vld_d.push_back(int'(o_stat_data));
      end
      if (o_busy && !busy_prev) start_t.push_back(t);
    end
    busy_prev = o_busy;
  end

  task automatic wait_t(input int target);
    int n = 0;
    while (t < target && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    chk("wait_budget", 64'(t >= target), 64'd1);
  endtask

  initial begin
    phy_data[0] = 16'h782D;
    phy_data[1] = 16'h7809;
    phy_data[2] = 16'h7809;
    phy_data[3] = 16'h7809;
    present = 4'b1111;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (10000) @(negedge i_clk);
    chk("idle_link", 64'(o_link_up), 64'h0);
    chk("idle_data", 64'(o_stat_data), 64'h0);
    chk("idle_idx", 64'(o_phy_idx), 64'h0);
    chk("idle_err", 64'(o_stat_err), 64'h0);
    chk("idle_busy", 64'(o_busy), 64'h0);

    i_initDn = 1'b1;
    @(negedge i_clk);
    wait_t(1545);
    present[2]  = 1'b0;
    phy_data[1] = 16'h782D;
    wait_t(1645);
    chk("r1_vld_count", 64'(vld_t.size()), 64'd4);
    if (vld_t.size() >= 4) begin
      chk("r1_vld0_t", 64'(vld_t[0]), 64'd384);
      chk("r1_vld1_t", 64'(vld_t[1]), 64'd769);
      chk("r1_vld3_t", 64'(vld_t[3]), 64'd1539);
      chk("r1_vld3_idx", 64'(vld_i[3]), 64'd3);
      chk("r1_vld0_data", 64'(vld_d[0]), 64'h782D);
    end
    chk("r1_start_count", 64'(start_t.size()), 64'd5);
    if (start_t.size() >= 5) chk("r2_start_t", 64'(start_t[4]), 64'd1640);
    chk("r1_link", 64'(o_link_up), 64'h1);

    wait_t(3285);
    if (vld_t.size() >= 8) begin
      chk("r2_vld1_t", 64'(vld_t[5]), 64'd2409);
      chk("r2_missing_err", 64'(vld_e[6]), 64'd1);
      chk("r2_missing_data", 64'(vld_d[6]), 64'hFFFF);
    end else chk("r2_vld_count", 64'(vld_t.size()), 64'd8);
    chk("r2_link", 64'(o_link_up), 64'h3);

    wait_t(3521);
    i_initDn = 1'b0;
    @(negedge i_clk);
    chk("abort_link", 64'(o_link_up), 64'h0);
    chk("abort_busy", 64'(o_busy), 64'h0);
    chk("abort_mdc", 64'(o_mdc), 64'h0);
    repeat (50) @(negedge i_clk);
    chk("abort_no_vld", 64'(vld_t.size()), 64'd8);
    i_initDn = 1'b1;
    @(negedge i_clk);
    wait_t(400);
    if (vld_t.size() >= 9) begin
      chk("restart_idx", 64'(vld_i[8]), 64'd0);
      chk("restart_t", 64'(vld_t[8]), 64'd384);
    end else chk("restart_vld_count", 64'(vld_t.size()), 64'd9);
    chk("restart_link", 64'(o_link_up), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdio_link_poll.md
# mdio_link_poll

Periodic MDIO link-status monitor for the four PHYs on the shared management bus. It idles until PHY initialisation reports done. It then issues Clause-22 MDIO read frames to register 1 (Basic Status) of PHY addresses 0–3 in turn and publishes each PHY's link bit to the MAC/DHCP logic. It owns MDC/MDIO only after init is done; the bus mux selecting between init writer and poller lives in the top level.

## Interface
Parameters:
- CLK_DIV, 16: i_clk cycles per MDC half-period; legal minimum 2.
- POLL_INTERVAL, 32'd1000000: idle i_clk cycles between the end of the PHY 3 read and the next PHY 0 read.
- STAT_REG, 5'd1: register address read from every PHY.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_initDn  in  1  PHY init complete, level; polling runs only while high.
- o_mdc  out  1  MDIO management clock.
- b_mdio  inout  1  MDIO data; driven only when internal oe=1, else 1'bz (external pull-up).
- o_link_up  out  4  bit i = link status of PHY i.
- o_stat_vld  out  1  one-cycle pulse: o_phy_idx/o_stat_data/o_stat_err valid.
- o_phy_idx  out  2  PHY address of the completed read.
- o_stat_data  out  16  register value read.
- o_stat_err  out  1  turnaround error on this read (no PHY responded).
- o_busy  out  1  high while a frame is on the bus.

## Operation
- States: IDLE, FRAME, UPDATE, WAIT.
- IDLE: bus released, o_mdc=0. On i_initDn=1 → FRAME with phy index 0; no initial wait.
- FRAME: 64 MDC bits, index 0..63, each bit = CLK_DIV cycles low then CLK_DIV cycles high.
  - Bits 0–31 preamble 1; 32–33 ST=01; 34–35 OP=10 (read); 36–40 PHYAD (phy index, zero-extended, MSB first); 41–45 REGAD=STAT_REG MSB first. oe=1 for bits 0–45.
  - Bits 46–63 oe=0. Bit 47 (TA second bit) sampled; value 1 sets the error flag for this read.
  - Bits 48–63: register data, MSB first, shifted in at each MDC rising edge.
- UPDATE: single cycle.
  - o_stat_vld=1; o_phy_idx, o_stat_data, o_stat_err loaded.
  - o_link_up[idx] ← data[2] if no error, else 0.
  - Other o_link_up bits hold.
  - If idx<3: idx+1 → FRAME. If idx=3: idx ← 0 → WAIT.
- WAIT: counts POLL_INTERVAL cycles with bus released, then → FRAME.
- i_initDn falling in any state: next cycle state=IDLE, oe=0, o_mdc=0, o_link_up=0, o_busy=0, idx=0. No o_stat_vld for an aborted frame.
- No internal data width overflow: bit counter 6 bits, phase counter sized for CLK_DIV, interval counter 32 bits.

## Timing
- Reset values (async, i_rst=1): state IDLE, o_mdc=0, oe=0 (b_mdio=z), o_link_up=4'b0, o_stat_vld=0, o_phy_idx=0, o_stat_data=16'h0, o_stat_err=0, o_busy=0. Reset during a frame aborts it immediately.
- Output timing: all outputs are registered. MDIO out/oe change in the same cycle that o_mdc goes 0→1... no: they change in the cycle o_mdc goes 1→0, i.e. at the start of each bit's low phase. This gives the PHY CLK_DIV cycles of setup and hold.
- Input sampling: b_mdio is sampled in the cycle o_mdc goes 0→1.
- First frame: o_mdc's first low phase begins the cycle after i_initDn is registered high; o_busy=1 from that cycle.
- Frame length: exactly 128·CLK_DIV cycles (2048 at default).
- Stat pulse: o_stat_vld pulses in the cycle after bit 63's high phase ends; o_busy=0 in that cycle.
- Back-to-back reads: the next frame's first low phase starts the cycle after UPDATE.
- Full cycle: one round of 4 reads plus wait = 4·(128·CLK_DIV+1) + POLL_INTERVAL cycles.
- o_mdc is 0 whenever o_busy=0.

## Test plan
- Reset / idle: i_rst pulse, i_initDn=0 for 10k cycles → all outputs at reset values, b_mdio=z, o_mdc static 0.
- Frame format: i_initDn=1; PHY model at address 0 returns 16'h782D → captured bits 0–45 = 32×1, 01, 10, 00000, 00001. o_stat_vld at cycle 2049 after start with o_phy_idx=0, o_stat_data=16'h782D, o_link_up=4'b0001.
- Scan order and wait: models 1–3 return 16'h7809 (link down) → vld pulses for idx 0,1,2,3 at 2049-cycle spacing; o_link_up=4'b0001. Next frame starts POLL_INTERVAL cycles after the idx-3 pulse.
- Missing PHY: model at address 2 absent (pull-up) → idx 2 pulse with o_stat_err=1, o_stat_data=16'hFFFF, o_link_up[2]=0.
- Link change: PHY1 data changes 16'h7809→16'h782D between rounds → o_link_up[1] rises only at the idx-1 pulse of the next round.
- Abort: drop i_initDn mid-frame (bit 40) → next cycle b_mdio=z, o_mdc=0, o_link_up=0, no vld. Re-raise → fresh frame starts at PHY 0.
